// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and receiver.
//   UART_NBITS     - default data bits per frame
//   UART_OS_TICKS  - default oversample ticks per bit
//   uart_tx_state_t - transmitter FSM states
//   cnt_width()    - counter width for a modulus, never below 1 bit
package uart_pkg;

   localparam int unsigned UART_NBITS    = 8;
   localparam int unsigned UART_OS_TICKS = 16;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop
   } uart_tx_state_t;

   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/uart_tx_core_if.sv
// uart_tx_core_if: transmit FIFO read port (first-word-fall-through).
//   fifo_empty - FIFO empty flag
//   fifo_dout  - head word, valid whenever fifo_empty is low
//   fifo_rd    - one-cycle pop strobe
// Modports: master = transmitter (pops), slave = FIFO.
interface uart_tx_core_if #(
   parameter int unsigned NBITS = 8
);

   logic             fifo_empty;
   logic [NBITS-1:0] fifo_dout;
   logic             fifo_rd;

   modport master (
      input  fifo_empty,
      input  fifo_dout,
      output fifo_rd
   );

   modport slave (
      output fifo_empty,
      output fifo_dout,
      input  fifo_rd
   );

endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: divides clk by CLK_DIV into a one-cycle tick.
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   clear - synchronous clear; the first tick after release comes CLK_DIV cycles later
//   tick  - one-cycle pulse every CLK_DIV cycles (every cycle when CLK_DIV = 1)
module uart_baud_tick
   import uart_pkg::*;
#(
   parameter int unsigned CLK_DIV = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   output logic tick
);

   localparam int unsigned   DivW    = cnt_width(CLK_DIV);
   localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

   logic [DivW-1:0] cnt_q, cnt_d;

   always_comb begin
      tick  = ~clear & (cnt_q == DivLast);
      cnt_d = cnt_q;
      if (clear || (cnt_q == DivLast)) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_tx_core.sv
// uart_tx_core: UART transmitter, 1 start + NBITS data (LSB first) + 1 stop bit,
// each bit OS_TICKS*CLK_DIV clock cycles long. Pops bytes from a FWFT FIFO.
//   clk     - clock, rising edge
//   rst_n   - asynchronous active-low reset
//   fifo    - FIFO read port (uart_tx_core_if.master)
//   tx      - registered serial output, idle high
//   tx_busy - high from the pop cycle until the end of the stop bit
//   tx_done - one-cycle pulse in the last cycle of the stop bit
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx_core
   import uart_pkg::*;
#(
   parameter int unsigned NBITS    = UART_NBITS,
   parameter int unsigned OS_TICKS = UART_OS_TICKS,
   parameter int unsigned CLK_DIV  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   uart_tx_core_if.master        fifo,
   output logic                  tx,
   output logic                  tx_busy,
   output logic                  tx_done
);

   localparam int unsigned     OsW     = cnt_width(OS_TICKS);
   localparam int unsigned     BitW    = cnt_width(NBITS);
   localparam logic [OsW-1:0]  OsLast  = OsW'(OS_TICKS - 1);
   localparam logic [BitW-1:0] BitLast = BitW'(NBITS - 1);

   uart_tx_state_t   state_q, state_d;
   logic [OsW-1:0]   os_q, os_d;
   logic [BitW-1:0]  bit_q, bit_d;
   logic [NBITS-1:0] shreg_q, shreg_d;
   logic             tx_q, tx_d;
   logic             tick;
   logic             bit_end;
   logic             pop;
`ifdef UART_TX_PARITY_EN
   logic             parity_q, parity_d;
`endif

   // Divider is held clear while idle, so it restarts from zero on every pop.
   uart_baud_tick #(
      .CLK_DIV (CLK_DIV)
   ) u_baud_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (state_q == StIdle),
      .tick  (tick)
   );

   assign bit_end = tick & (os_q == OsLast);

   always_comb begin
      state_d = state_q;
      os_d    = os_q;
      bit_d   = bit_q;
      shreg_d = shreg_q;
`ifdef UART_TX_PARITY_EN
      parity_d = parity_q;
`endif
      pop     = 1'b0;
      tx_done = 1'b0;

      if (tick) begin
         os_d = (os_q == OsLast) ? '0 : os_q + 1'b1;
      end

      case (state_q)
         StIdle: begin
            if (!fifo.fifo_empty) begin
               pop     = 1'b1;
               shreg_d = fifo.fifo_dout;
`ifdef UART_TX_PARITY_EN
               parity_d = ^fifo.fifo_dout;
`endif
               os_d    = '0;
               bit_d   = '0;
               state_d = StStart;
            end
         end
         StStart: begin
            if (bit_end) state_d = StData;
         end
         StData: begin
            if (bit_end) begin
               shreg_d = shreg_q >> 1;
               if (bit_q == BitLast) begin
                  bit_d = '0;
`ifdef UART_TX_PARITY_EN
                  state_d = StParity;
`else
                  state_d = StStop;
`endif
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         StParity: begin
            if (bit_end) state_d = StStop;
         end
`endif
         StStop: begin
            if (bit_end) begin
               tx_done = 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      // Line level follows the next state so tx is registered yet aligned with the FSM.
      case (state_d)
         StStart:  tx_d = 1'b0;
         StData:   tx_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
         StParity: tx_d = parity_d;
`endif
         default:  tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         os_q    <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         os_q    <= os_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         tx_q    <= tx_d;
      end
   end

`ifdef UART_TX_PARITY_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         parity_q <= 1'b0;
      end else begin
         parity_q <= parity_d;
      end
   end
`endif

   // Pop is combinational from idle state; gating with rst_n keeps it quiet while in reset.
   assign fifo.fifo_rd = pop & rst_n;
   assign tx_busy      = (state_q != StIdle) | fifo.fifo_rd;
   assign tx           = tx_q;

endmodule

// File: tb/tb_uart_tx_core.sv
// tb_uart_tx_core: directed self-checking bench for uart_tx_core.
// Two instances: CLK_DIV = 1 and CLK_DIV = 3, OS_TICKS = 16, NBITS = 8.
// Follows UART_TX_PARITY_EN for the expected frame length and parity tests.
module tb_uart_tx_core;

   localparam int unsigned NB = 8;
   localparam int unsigned OS = 16;
`ifdef UART_TX_PARITY_EN
   localparam int unsigned NF = NB + 3;
`else
   localparam int unsigned NF = NB + 2;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   uart_tx_core_if #(.NBITS(NB)) fif1 ();
   uart_tx_core_if #(.NBITS(NB)) fif3 ();

   logic tx1, busy1, done1;
   logic tx3, busy3, done3;

   uart_tx_core #(
      .NBITS    (NB),
      .OS_TICKS (OS),
      .CLK_DIV  (1)
   ) u_dut1 (
      .clk     (clk),
      .rst_n   (rst_n),
      .fifo    (fif1),
      .tx      (tx1),
      .tx_busy (busy1),
      .tx_done (done1)
   );

   uart_tx_core #(
      .NBITS    (NB),
      .OS_TICKS (OS),
      .CLK_DIV  (3)
   ) u_dut3 (
      .clk     (clk),
      .rst_n   (rst_n),
      .fifo    (fif3),
      .tx      (tx3),
      .tx_busy (busy3),
      .tx_done (done3)
   );

   int unsigned cyc   = 0;
   int unsigned pops1 = 0;
   int unsigned pops3 = 0;
   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (fif1.fifo_rd) pops1 <= pops1 + 1;
      if (fif3.fifo_rd) pops3 <= pops3 + 1;
   end

   // Selected instance: 0 -> CLK_DIV=1, 1 -> CLK_DIV=3.
   logic        sel = 1'b0;
   logic        m_tx, m_busy, m_done, m_rd;
   int unsigned m_pops;
   assign m_tx   = sel ? tx3 : tx1;
   assign m_busy = sel ? busy3 : busy1;
   assign m_done = sel ? done3 : done1;
   assign m_rd   = sel ? fif3.fifo_rd : fif1.fifo_rd;
   assign m_pops = sel ? pops3 : pops1;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic set_fifo(input logic empty, input logic [NB-1:0] dout);
      if (sel) begin
         fif3.fifo_empty = empty;
         fif3.fifo_dout  = dout;
      end else begin
         fif1.fifo_empty = empty;
         fif1.fifo_dout  = dout;
      end
   endtask

   // Frame in transmit order, bit 0 = start bit. p is the hand-computed even parity.
   function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic p);
`ifdef UART_TX_PARITY_EN
      return {1'b1, p, b, 1'b0};
`else
      return {1'b0, 1'b1, b, 1'b0};
`endif
   endfunction

   // Waits (bounded) for a pop, starting at the next falling edge.
   task automatic wait_pop(output int unsigned t, output int unsigned waited);
      waited = 0;
      @(negedge clk);
      while (!m_rd && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      check_val("pop_seen", {31'd0, m_rd}, 32'd1);
      t = cyc;
   endtask

   // Entered at the falling edge of the pop cycle; checks every cycle of the frame.
   task automatic run_frame(input logic [10:0] fr, input logic keep, input logic [NB-1:0] nxt);
      int unsigned b  = sel ? 48 : 16;
      int unsigned p0 = m_pops;
      check_val("pop_tx_idle", {31'd0, m_tx}, 32'd1);
      check_val("pop_busy", {31'd0, m_busy}, 32'd1);
      @(posedge clk);
      #1;
      set_fifo(!keep, nxt);
      check_val("pop_count", m_pops, p0 + 1);
      for (int unsigned k = 1; k <= NF * b; k++) begin
         @(negedge clk);
         check_val($sformatf("tx_bit%0d", (k - 1) / b), {31'd0, m_tx}, {31'd0, fr[(k-1)/b]});
         check_val("busy", {31'd0, m_busy}, 32'd1);
         check_val("no_pop", {31'd0, m_rd}, 32'd0);
         check_val("done", {31'd0, m_done}, {31'd0, k == NF * b});
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned t1, t2, w, p;

      fif1.fifo_empty = 1'b0;
      fif1.fifo_dout  = 8'h55;
      fif3.fifo_empty = 1'b1;
      fif3.fifo_dout  = 8'h00;

      // Reset held 5 cycles with a non-empty FIFO.
      repeat (5) begin
         @(negedge clk);
         check_val("rst_tx", {31'd0, tx1}, 32'd1);
         check_val("rst_rd", {31'd0, fif1.fifo_rd}, 32'd0);
         check_val("rst_busy", {31'd0, busy1}, 32'd0);
         check_val("rst_done", {31'd0, done1}, 32'd0);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      wait_pop(t1, w);
      check_val("first_pop_delay", w, 32'd0);
      run_frame(mk_frame(8'h55, 1'b0), 1'b0, 8'h55);
      @(negedge clk);
      check_val("idle_rd", {31'd0, m_rd}, 32'd0);
      check_val("idle_tx", {31'd0, m_tx}, 32'd1);
      check_val("idle_busy", {31'd0, m_busy}, 32'd0);

      // Single byte 0xA5: line 0,1,0,1,0,0,1,0,1,1 (parity 0 when enabled).
      @(posedge clk);
      #1;
      set_fifo(1'b0, 8'hA5);
      p = pops1;
      wait_pop(t1, w);
      run_frame(mk_frame(8'hA5, 1'b0), 1'b0, 8'h00);
      repeat (3) @(negedge clk);
      check_val("a5_single_pop", pops1, p + 1);

      // Back-to-back 0x00 then 0xFF.
      @(posedge clk);
      #1;
      set_fifo(1'b0, 8'h00);
      wait_pop(t1, w);
      run_frame(mk_frame(8'h00, 1'b0), 1'b1, 8'hFF);
      wait_pop(t2, w);
      check_val("b2b_gap_wait", w, 32'd0);
      check_val("b2b_spacing", t2 - t1, NF * 16 + 1);
      run_frame(mk_frame(8'hFF, 1'b0), 1'b0, 8'h00);

`ifdef UART_TX_PARITY_EN
      // Parity: 0x07 has three ones -> 1; 0x03 has two ones -> 0.
      @(posedge clk);
      #1;
      set_fifo(1'b0, 8'h07);
      wait_pop(t1, w);
      run_frame(mk_frame(8'h07, 1'b1), 1'b0, 8'h00);
      @(posedge clk);
      #1;
      set_fifo(1'b0, 8'h03);
      wait_pop(t1, w);
      run_frame(mk_frame(8'h03, 1'b0), 1'b0, 8'h00);
`endif

      // Reset during data bit 4 of 0xF0 (cycles T+81..T+96).
      @(posedge clk);
      #1;
      set_fifo(1'b0, 8'hF0);
      wait_pop(t1, w);
      @(posedge clk);
      #1;
      set_fifo(1'b1, 8'hF0);
      p = pops1;
      repeat (88) @(negedge clk);
      check_val("mid_bit4_tx", {31'd0, tx1}, 32'd1);
      check_val("mid_busy", {31'd0, busy1}, 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      check_val("rst_async_tx", {31'd0, tx1}, 32'd1);
      check_val("rst_async_busy", {31'd0, busy1}, 32'd0);
      repeat (2) @(negedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (40) begin
         @(negedge clk);
         check_val("post_rst_tx", {31'd0, tx1}, 32'd1);
         check_val("post_rst_rd", {31'd0, fif1.fifo_rd}, 32'd0);
         check_val("post_rst_busy", {31'd0, busy1}, 32'd0);
      end
      check_val("post_rst_pops", pops1, p);

      // CLK_DIV = 3: 0x81 popped, head changes to 0x00 the next cycle.
      sel = 1'b1;
      @(posedge clk);
      #1;
      set_fifo(1'b0, 8'h81);
      wait_pop(t1, w);
      run_frame(mk_frame(8'h81, 1'b0), 1'b0, 8'h00);
      @(negedge clk);
      check_val("div3_idle_busy", {31'd0, m_busy}, 32'd0);
      check_val("div3_pops", pops3, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_tx_core.md
# uart_tx_core

UART transmitter, the transmit-side counterpart of the team's 16x-oversampled UART receiver, using the same 1 start bit + 8 data bits + 1 stop bit, LSB-first frame. It pops bytes from a first-word-fall-through transmit FIFO and serializes them onto the `tx` line. Bit timing comes from an internal oversample-tick generator, so every bit lasts exactly `OS_TICKS*CLK_DIV` clock cycles.

## Interface
- `NBITS`, 8: data bits per frame.
- `OS_TICKS`, 16: oversample ticks per bit. Must match the receiver.
- `CLK_DIV`, 16: `clk` cycles per oversample tick. Must be ≥1.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `fifo_empty` input 1: TX FIFO empty flag.
- `fifo_dout` input NBITS: FIFO head word (first-word-fall-through).
- `fifo_rd` output 1: one-cycle pop strobe.
- `tx` output 1: serial line. Registered; idle high.
- `tx_busy` output 1: high from the pop cycle until the end of the stop bit.
- `tx_done` output 1: one-cycle pulse when the stop bit completes.

## Operation
- States: IDLE → START → DATA → [PARITY] → STOP → IDLE.
- **IDLE:** `tx`=1. If `fifo_empty`=0:
  - assert `fifo_rd` for one cycle;
  - latch `fifo_dout` into the shift register in that same cycle;
  - clear the tick divider, oversample counter and bit counter;
  - go to START.
- **START:** `tx`=0 for `OS_TICKS` ticks, then go to DATA.
- **DATA:** `tx`=`shreg[0]`. After `OS_TICKS` ticks, shift right and increment the bit counter. After bit `NBITS-1`, go to PARITY if enabled, otherwise STOP.
- **PARITY:** `tx`= even parity (XOR of the latched byte) for `OS_TICKS` ticks.
- **STOP:** `tx`=1 for `OS_TICKS` ticks. On the last tick:
  - pulse `tx_done`;
  - deassert `tx_busy`;
  - go to IDLE.
- `fifo_dout` is sampled only in the pop cycle. Later changes are ignored.
- No pop while in any non-IDLE state, even if the FIFO is non-empty.
- Counter widths:
  - oversample counter `$clog2(OS_TICKS)`, wraps to 0 at `OS_TICKS-1`;
  - bit counter `$clog2(NBITS)`, wraps at `NBITS-1`;
  - divider `$clog2(CLK_DIV)`, minimum width 1.
- `CLK_DIV`=1: a tick occurs every cycle.

## Timing
- Reset values: `tx`=1, `fifo_rd`=0, `tx_busy`=0, `tx_done`=0, state IDLE, all counters 0, shift register 0.
- Pop at cycle T. `tx` falls at T+1. Each bit lasts `B` = `OS_TICKS*CLK_DIV` cycles.
- `tx_done` is asserted in cycle T+`B`·(NBITS+2). Add `B` with parity enabled.
- Back-to-back frames: IDLE lasts exactly 1 cycle (`tx`=1) between a stop bit and the next start bit.
- Reset mid-frame: `tx` returns to 1 immediately (asynchronous). The in-flight byte is lost and is not re-popped. After release, the block behaves as from power-up.
- `fifo_empty` rising during a frame has no effect on that frame.

## Configuration
- `UART_TX_PARITY_EN`
  - Defined: the PARITY state and even-parity bit are inserted between the last data bit and the stop bit. Frame = NBITS+3 bits.
  - Undefined: the PARITY state and logic are absent. Frame = NBITS+2 bits.
- The receiver must be built with the matching setting.

## Structure
- Package `uart_pkg`:
  - state enum `uart_tx_state_t` (IDLE, START, DATA, PARITY, STOP);
  - defaults `UART_NBITS`=8 and `UART_OS_TICKS`=16, shared with the receiver.
- Sub-module `uart_baud_tick`: `CLK_DIV` counter with synchronous clear, emitting a one-cycle `tick`. Reusable by the receiver.

## Test plan
- Reset with `CLK_DIV`=1, `OS_TICKS`=16, FIFO holding 0x55: hold `rst_n` low for 5 cycles → `tx`=1 and `fifo_rd`/`tx_busy`/`tx_done`=0 throughout; first pop is the cycle after release.
- Single byte 0xA5, `CLK_DIV`=1 → `tx` = 0,1,0,1,0,0,1,0,1,1, each bit 16 cycles; `tx_done` in cycle T+160; exactly one `fifo_rd`.
- Back-to-back 0x00 then 0xFF → two pops 161 cycles apart; exactly one high cycle between the first frame's stop bit and the second frame's start bit.
- `UART_TX_PARITY_EN` defined, byte 0x07 → parity bit 1, frame 176 cycles; byte 0x03 → parity bit 0.
- Assert `rst_n` low during data bit 4 of 0xF0 → `tx`=1 within the same cycle, `tx_busy`=0; FIFO now empty → no pop after release; `tx` stays 1.
- `CLK_DIV`=3; `fifo_dout` changed to 0x00 one cycle after popping 0x81 → start bit 48 cycles long, transmitted data still 0x81.
